// File: rtl/wash_sequencer_if.sv
// Handshake bundle between the wash sequencer, its program ROM and the actuator drivers.
// The master side (controller/bench) drives commands and ROM data; the slave side is the sequencer.
interface wash_sequencer_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
);
  logic                   start;
  logic                   stop;
  logic                   pause;
  logic                   tick;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   fill_valve;
  logic                   drain_valve;
  logic                   motor_fwd;
  logic                   motor_rev;
  logic                   busy;
  logic                   halted;
  logic                   fault;

  modport master (
    output start, stop, pause, tick, instr,
    input  pc, fill_valve, drain_valve, motor_fwd, motor_rev, busy, halted, fault
  );

  modport slave (
    input  start, stop, pause, tick, instr,
    output pc, fill_valve, drain_valve, motor_fwd, motor_rev, busy, halted, fault
  );
endinterface

// File: rtl/wash_sequencer.sv
// Program sequencer for the washing register machine: fetches {imm,reg,op} words by pc and drives
// valves/motor paced by tick. Optional runaway-loop watchdog enabled by macro WASH_SEQ_WATCHDOG_EN.
module wash_sequencer #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 4,
  parameter int ENTRY_ADDR  = 2,
  parameter int WDOG_LIMIT  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  wash_sequencer_if.slave bus
);

  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [7:0] OP_HALT    = 8'h00;
  localparam logic [7:0] OP_WAIT    = 8'h11;
  localparam logic [7:0] OP_FILL    = 8'h12;
  localparam logic [7:0] OP_RELEASE = 8'h13;
  localparam logic [7:0] OP_FWD     = 8'h14;
  localparam logic [7:0] OP_REV     = 8'h15;
  localparam logic [7:0] OP_SET     = 8'h21;
  localparam logic [7:0] OP_DEC     = 8'h22;
  localparam logic [7:0] OP_J       = 8'h30;
  localparam logic [7:0] OP_JZ      = 8'h31;
  localparam logic [7:0] OP_JNZ     = 8'h32;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_TIMED, S_HALTED, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE, ACT_FILL, ACT_DRAIN, ACT_FWD, ACT_REV
  } act_t;

  state_t                state_q, state_d;
  act_t                  act_q, act_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           timer_q, timer_d;
  logic                  fill_q, fill_d;
  logic                  drain_q, drain_d;
  logic                  fwd_q, fwd_d;
  logic                  rev_q, rev_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;

  logic [15:0]           regs_q [NUM_REGS];
  logic [15:0]           regs_d [NUM_REGS];

  logic [INSTR_WIDTH-1:0] instr_w;
  logic [7:0]             op;
  logic [7:0]             rsel;
  logic [15:0]            imm;
  logic [IDXW-1:0]        reg_idx;
  logic                   reg_ok;
  logic [15:0]            reg_val;
  logic [ADDR_WIDTH-1:0]  pc_inc;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   reg_we;
  logic [15:0]            reg_wdata;
  logic                   untimed;
  logic                   run;

  assign instr_w = bus.instr;
  assign op      = instr_w[7:0];
  assign rsel    = instr_w[15:8];
  assign imm     = instr_w[31:16];
  assign reg_idx = rsel[IDXW-1:0];
  assign reg_ok  = (int'(rsel) < NUM_REGS);
  assign reg_val = reg_ok ? regs_q[reg_idx] : 16'd0;
  assign pc_inc  = pc_q + 1'b1;
  assign target  = imm[ADDR_WIDTH-1:0];

`ifdef WASH_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_LIMIT + 1) + 1;
  logic [WDW-1:0] wdog_q, wdog_d;
`else
  // The limit is only meaningful with the watchdog compiled in.
  if (WDOG_LIMIT < 0) begin : g_wdog_unused
  end
`endif

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    pc_d      = pc_q;
    timer_d   = timer_q;
    reg_we    = 1'b0;
    reg_wdata = 16'd0;
    untimed   = 1'b0;
    if (bus.stop) begin
      state_d = S_IDLE;
      act_d   = ACT_NONE;
      pc_d    = '0;
      timer_d = 16'd0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (bus.start) begin
            pc_d    = ADDR_WIDTH'(ENTRY_ADDR);
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (!bus.pause) begin
            case (op)
              OP_HALT: state_d = S_HALTED;
              OP_WAIT, OP_FILL, OP_RELEASE, OP_FWD, OP_REV: begin
                timer_d = imm;
                if (imm != 16'd0) begin
                  state_d = S_TIMED;
                  case (op)
                    OP_FILL:    act_d = ACT_FILL;
                    OP_RELEASE: act_d = ACT_DRAIN;
                    OP_FWD:     act_d = ACT_FWD;
                    OP_REV:     act_d = ACT_REV;
                    default:    act_d = ACT_NONE;
                  endcase
                end else begin
                  pc_d    = pc_inc;
                  untimed = 1'b1;
                end
              end
              OP_SET, OP_DEC: begin
                if (reg_ok) begin
                  reg_we    = 1'b1;
                  reg_wdata = (op == OP_SET) ? imm : reg_val - 16'd1;
                  pc_d      = pc_inc;
                  untimed   = 1'b1;
                end else begin
                  state_d = S_FAULT;
                end
              end
              OP_J: begin
                pc_d    = target;
                untimed = 1'b1;
              end
              OP_JZ, OP_JNZ: begin
                if (reg_ok) begin
                  pc_d    = ((reg_val == 16'd0) == (op == OP_JZ)) ? target : pc_inc;
                  untimed = 1'b1;
                end else begin
                  state_d = S_FAULT;
                end
              end
              default: state_d = S_FAULT;
            endcase
          end
        end
        S_TIMED: begin
          // Paused ticks are dropped, not deferred.
          if (!bus.pause && bus.tick) begin
            timer_d = timer_q - 16'd1;
            if (timer_q == 16'd1) begin
              state_d = S_EXEC;
              act_d   = ACT_NONE;
              pc_d    = pc_inc;
            end
          end
        end
        default: ;
      endcase
`ifdef WASH_SEQ_WATCHDOG_EN
      // The instruction that would exceed the limit is not executed.
      if (untimed && (wdog_q >= WDW'(WDOG_LIMIT))) begin
        state_d = S_FAULT;
        pc_d    = pc_q;
        timer_d = timer_q;
        reg_we  = 1'b0;
      end
`endif
    end

`ifdef WASH_SEQ_WATCHDOG_EN
    if (state_d != S_EXEC) begin
      wdog_d = '0;
    end else if (untimed) begin
      wdog_d = wdog_q + 1'b1;
    end else begin
      wdog_d = wdog_q;
    end
`endif

    // Actuators follow the next state so they rise after the EXEC cycle and drop with the last tick.
    run      = (state_d == S_TIMED) && !bus.pause;
    fill_d   = run && (act_d == ACT_FILL);
    drain_d  = run && (act_d == ACT_DRAIN);
    fwd_d    = run && (act_d == ACT_FWD);
    rev_d    = run && (act_d == ACT_REV);
    busy_d   = (state_d == S_EXEC) || (state_d == S_TIMED);
    halted_d = (state_d == S_HALTED);
    fault_d  = (state_d == S_FAULT);
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      assign regs_d[gi] = (reg_we && (reg_idx == IDXW'(gi))) ? reg_wdata : regs_q[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[gi] <= 16'd0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      act_q    <= ACT_NONE;
      pc_q     <= '0;
      timer_q  <= 16'd0;
      fill_q   <= 1'b0;
      drain_q  <= 1'b0;
      fwd_q    <= 1'b0;
      rev_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef WASH_SEQ_WATCHDOG_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      pc_q     <= pc_d;
      timer_q  <= timer_d;
      fill_q   <= fill_d;
      drain_q  <= drain_d;
      fwd_q    <= fwd_d;
      rev_q    <= rev_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
`ifdef WASH_SEQ_WATCHDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fill_valve  = fill_q;
  assign bus.drain_valve = drain_q;
  assign bus.motor_fwd   = fwd_q;
  assign bus.motor_rev   = rev_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: stock wash program, pause, faults, stop, watchdog, async reset.
module tb_wash_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wash_sequencer_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  wash_sequencer #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(4), .ENTRY_ADDR(2), .WDOG_LIMIT(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] rom [0:255];
  assign bus.instr = rom[bus.pc];

  int tests = 0;
  int fails = 0;
  bit auto_tick = 1'b0;
  int tdiv = 0;

  // Activity monitor, sampled mid-cycle.
  bit mon_clr = 1'b1;
  int fill_ticks, drain_ticks, fwd_ticks, rev_ticks;
  int fill_rises, drain_rises, fwd_rises, rev_rises;
  int fill_run, fill_first, gap_ticks, overlap;
  logic fill_p, drain_p, fwd_p, rev_p;

  always @(negedge clk) begin
    if (mon_clr) begin
      fill_ticks <= 0; drain_ticks <= 0; fwd_ticks <= 0; rev_ticks <= 0;
      fill_rises <= 0; drain_rises <= 0; fwd_rises <= 0; rev_rises <= 0;
      fill_run <= 0; fill_first <= -1; gap_ticks <= 0; overlap <= 0;
      fill_p <= 1'b0; drain_p <= 1'b0; fwd_p <= 1'b0; rev_p <= 1'b0;
    end else begin
      if (bus.fill_valve && bus.tick) begin
        fill_ticks <= fill_ticks + 1;
        fill_run   <= fill_run + 1;
      end
      if (bus.drain_valve && bus.tick) drain_ticks <= drain_ticks + 1;
      if (bus.motor_fwd && bus.tick)   fwd_ticks   <= fwd_ticks + 1;
      if (bus.motor_rev && bus.tick)   rev_ticks   <= rev_ticks + 1;
      if (bus.fill_valve && !fill_p)   fill_rises  <= fill_rises + 1;
      if (bus.drain_valve && !drain_p) drain_rises <= drain_rises + 1;
      if (bus.motor_fwd && !fwd_p)     fwd_rises   <= fwd_rises + 1;
      if (bus.motor_rev && !rev_p)     rev_rises   <= rev_rises + 1;
      if (!bus.fill_valve && fill_p && fill_first < 0) fill_first <= fill_run;
      if (bus.busy && bus.tick &&
          !(bus.fill_valve || bus.drain_valve || bus.motor_fwd || bus.motor_rev))
        gap_ticks <= gap_ticks + 1;
      if ($countones({bus.fill_valve, bus.drain_valve, bus.motor_fwd, bus.motor_rev}) > 1)
        overlap <= overlap + 1;
      fill_p  <= bus.fill_valve;
      drain_p <= bus.drain_valve;
      fwd_p   <= bus.motor_fwd;
      rev_p   <= bus.motor_rev;
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] r,
                                      input logic [15:0] imm);
    return {imm, r, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    if (auto_tick) begin
      bus.tick = (tdiv == 3);
      tdiv = (tdiv + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    cyc();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  function automatic logic [6:0] outs();
    return {bus.fill_valve, bus.drain_valve, bus.motor_fwd, bus.motor_rev,
            bus.busy, bus.halted, bus.fault};
  endfunction

  initial begin
    int n;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    clear_rom();

    // Reset values
    cyc(); cyc();
    check("reset_pc", 32'(bus.pc), 32'd0);
    check("reset_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Stock program
    rom[2]  = ins(8'h12, 8'd0, 16'd100);
    rom[3]  = ins(8'h11, 8'd0, 16'd50);
    rom[4]  = ins(8'h21, 8'd0, 16'd5);
    rom[5]  = ins(8'h14, 8'd0, 16'd20);
    rom[6]  = ins(8'h15, 8'd0, 16'd20);
    rom[7]  = ins(8'h22, 8'd0, 16'd0);
    rom[8]  = ins(8'h32, 8'd0, 16'd5);
    rom[9]  = ins(8'h13, 8'd0, 16'd100);
    rom[10] = ins(8'h21, 8'd1, 16'd3);
    rom[11] = ins(8'h12, 8'd0, 16'd50);
    rom[12] = ins(8'h21, 8'd0, 16'd5);
    rom[13] = ins(8'h14, 8'd0, 16'd20);
    rom[14] = ins(8'h15, 8'd0, 16'd20);
    rom[15] = ins(8'h22, 8'd0, 16'd0);
    rom[16] = ins(8'h32, 8'd0, 16'd13);
    rom[17] = ins(8'h13, 8'd0, 16'd50);
    rom[18] = ins(8'h22, 8'd1, 16'd0);
    rom[19] = ins(8'h32, 8'd1, 16'd11);
    rom[20] = ins(8'h14, 8'd0, 16'd200);
    rom[21] = ins(8'h30, 8'd0, 16'd0);
    clear_mon();
    pulse_start();
    check("start_pc", 32'(bus.pc), 32'd2);
    check("start_busy", 32'(bus.busy), 32'd1);
    cyc();
    check("fill_on", 32'(bus.fill_valve), 32'd1);
    auto_tick = 1'b1;
    tdiv = 0;
    n = 0;
    while (!bus.halted && n < 20000) begin cyc(); n++; end
    auto_tick = 1'b0;
    bus.tick = 1'b0;
    check("stock_halted", 32'(bus.halted), 32'd1);
    check("stock_pc", 32'(bus.pc), 32'd0);
    check("stock_outs", 32'(outs()), 32'b0000010);
    check("first_fill_ticks", 32'(fill_first), 32'd100);
    check("wait_gap_ticks", 32'(gap_ticks), 32'd50);
    check("fill_ticks", 32'(fill_ticks), 32'd250);
    check("drain_ticks", 32'(drain_ticks), 32'd250);
    check("fwd_ticks", 32'(fwd_ticks), 32'd600);
    check("rev_ticks", 32'(rev_ticks), 32'd400);
    check("fill_rises", 32'(fill_rises), 32'd4);
    check("drain_rises", 32'(drain_rises), 32'd4);
    check("fwd_rises", 32'(fwd_rises), 32'd21);
    check("rev_rises", 32'(rev_rises), 32'd20);
    check("overlap", 32'(overlap), 32'd0);

    // Pause mid-fill at timer=40
    clear_rom();
    rom[2] = ins(8'h12, 8'd0, 16'd100);
    clear_mon();
    pulse_start();
    cyc();
    check("p_fill_on", 32'(bus.fill_valve), 32'd1);
    repeat (60) tick_pulse();
    bus.pause = 1'b1;
    cyc();
    check("p_fill_off", 32'(bus.fill_valve), 32'd0);
    repeat (30) tick_pulse();
    check("p_still_off", 32'(bus.fill_valve), 32'd0);
    check("p_busy_pc", 32'({bus.busy, bus.pc}), 32'h102);
    bus.pause = 1'b0;
    cyc();
    check("p_resume", 32'(bus.fill_valve), 32'd1);
    repeat (39) tick_pulse();
    check("p_39_more", 32'({bus.fill_valve, bus.pc}), 32'h102);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    check("p_40th", 32'({bus.fill_valve, bus.busy, bus.pc}), 32'h103);
    cyc();
    check("p_halt", 32'({bus.halted, bus.pc}), 32'h103);
    check("p_total_ticks", 32'(fill_ticks), 32'd100);

    // dec wraps, jz not taken
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    clear_rom();
    rom[2]  = ins(8'h22, 8'd0, 16'd0);
    rom[3]  = ins(8'h31, 8'd0, 16'd10);
    pulse_start();
    cyc();
    check("dec_pc", 32'(bus.pc), 32'd3);
    cyc();
    check("jz_pc", 32'(bus.pc), 32'd4);
    cyc();
    check("jz_halt", 32'({bus.halted, bus.pc}), 32'h104);
    check("dec_r0", 32'(dut.regs_q[0]), 32'hFFFF);

    // Illegal opcode, then bad register index
    rom[2] = ins(8'h7F, 8'd0, 16'd0);
    pulse_start();
    cyc();
    check("bad_op_fault", 32'(outs()), 32'b0000001);
    pulse_start();
    check("fault_holds", 32'(bus.fault), 32'd1);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    check("fault_stop", 32'({outs(), bus.pc}), 32'h0);
    rom[2] = ins(8'h21, 8'd4, 16'd7);
    pulse_start();
    cyc();
    check("bad_reg_fault", 32'(outs()), 32'b0000001);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;

    // Stop during reverse at timer=5, start in the same cycle
    rom[2] = ins(8'h15, 8'd0, 16'd10);
    rom[3] = ins(8'h00, 8'd0, 16'd0);
    pulse_start();
    cyc();
    check("rev_on", 32'(bus.motor_rev), 32'd1);
    repeat (5) tick_pulse();
    check("rev_t5", 32'(bus.motor_rev), 32'd1);
    bus.stop = 1'b1; bus.start = 1'b1;
    cyc();
    bus.stop = 1'b0; bus.start = 1'b0;
    check("stop_rev", 32'({outs(), bus.pc}), 32'h0);
    cyc();
    check("stop_start_ignored", 32'(bus.busy), 32'd0);

    // Jump to self
    rom[2] = ins(8'h30, 8'd0, 16'd2);
    pulse_start();
`ifdef WASH_SEQ_WATCHDOG_EN
    repeat (64) cyc();
    check("wdog_64", 32'(bus.fault), 32'd0);
    cyc();
    check("wdog_65", 32'(bus.fault), 32'd1);
`else
    repeat (1000) cyc();
    check("loop_no_fault", 32'({bus.fault, bus.busy, bus.pc}), 32'h102);
`endif
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;

    // Asynchronous reset mid-fill
    rom[2] = ins(8'h12, 8'd0, 16'd100);
    pulse_start();
    cyc();
    check("ar_fill_on", 32'(bus.fill_valve), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_async", 32'({outs(), bus.pc}), 32'h0);
    cyc();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer for the washing register machine. Fetches 32-bit instructions from the program ROM by driving `pc` and executes them. Each instruction is `{imm[15:0], reg[7:0], op[7:0]}`. Results drive the fill valve, drain valve and drum motor outputs, paced by an external time-base strobe. Sits between the program ROM and the appliance actuator drivers.

## Interface
- `INSTR_WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 8, program address width
- `NUM_REGS`, 4, number of 16-bit loop registers
- `ENTRY_ADDR`, 2, address loaded into `pc` on `start`
- `WDOG_LIMIT`, 64, watchdog limit in untimed instructions (only with the watchdog macro)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; begin the program at `ENTRY_ADDR`
- `stop` in 1: synchronous abort to IDLE
- `pause` in 1: level; freezes execution (door open)
- `tick` in 1: one-cycle time-base strobe
- `instr` in INSTR_WIDTH: ROM data, combinational from `pc`
- `pc` out ADDR_WIDTH: program counter
- `fill_valve`, `drain_valve`, `motor_fwd`, `motor_rev` out 1: registered actuator enables
- `busy` out 1: high in EXEC or TIMED
- `halted` out 1: high in HALTED
- `fault` out 1: high in FAULT

## Operation
- States: IDLE, EXEC, TIMED, HALTED, FAULT.
- Reset values: state=IDLE, `pc`=0, all registers=0, all outputs 0.
- IDLE/HALTED, `start`=1: `pc`←ENTRY_ADDR, go to EXEC. In HALTED, `pc` holds at the halt address until then.
- EXEC decodes `instr` in one cycle:
  - 0x00 halt: go to HALTED; `pc` unchanged.
  - 0x11 wait, 0x12 fill, 0x13 release, 0x14 forward, 0x15 reverse: timer←imm.
    - imm≠0: go to TIMED; the matching output goes high next cycle (fill→`fill_valve`, release→`drain_valve`, forward→`motor_fwd`, reverse→`motor_rev`; wait drives none).
    - imm=0: `pc`+1 with no output pulse.
  - 0x21 set: R[reg]←imm; `pc`+1.
  - 0x22 dec: R[reg]←R[reg]−1, modulo 2^16 (0→0xFFFF); `pc`+1.
  - 0x30 j: `pc`←imm[ADDR_WIDTH-1:0].
  - 0x31 jz / 0x32 jnz: branch to imm[ADDR_WIDTH-1:0] if R[reg]==0 / ≠0, else `pc`+1. The test uses the register value before any write in the same cycle; none occur.
  - Any other opcode, or reg≥NUM_REGS on set/dec/jz/jnz: go to FAULT.
- TIMED:
  - Each `tick` with `pause`=0 decrements the timer.
  - The tick that takes the timer 1→0 sets `pc`+1 and returns to EXEC.
  - The active output drops in the same cycle as that state change.
- At most one actuator output is high at any time; `motor_fwd` and `motor_rev` are never both high.
- `pause`=1: EXEC does not decode, TIMED ignores `tick`, all actuator outputs forced 0. Timer, `pc` and state are retained; on release, the output resumes next cycle.
- `stop`=1 in any state: go to IDLE, `pc`←0, outputs 0, registers retained. `stop` has priority over `start`, `pause` and `tick`.
- FAULT: all outputs 0, `fault`=1; exits only via `stop` or reset.
- `start` while busy is ignored.

## Timing
- Untimed instruction: 1 cycle.
- Timed instruction with imm=N≥1: EXEC cycle, then output high from the next cycle through the N-th unpaused tick. Next decode is the cycle after that tick.
- `tick` in the EXEC cycle of a timed instruction is not counted.
- `pc` changes only on the clock edge; ROM data is used the same cycle.
- `rst_n` low mid-operation: everything returns to reset values immediately, without waiting for a clock edge.

## Configuration
- `WASH_SEQ_WATCHDOG_EN` defined:
  - A counter counts consecutive untimed instructions executed in EXEC.
  - Entering TIMED or HALTED clears it.
  - Exceeding `WDOG_LIMIT` goes to FAULT, which catches runaway loops such as `j` to self.
- Undefined: no counter; `WDOG_LIMIT` unused; untimed loops run indefinitely.

## Test plan
- Reset, `start`, stock program, `tick` every 4 cycles → `pc`=2. `fill_valve` is high for exactly 100 ticks, then 50 idle ticks. Five forward-20/reverse-20 pairs follow, then `drain_valve` for 100 ticks.
- Full stock program → rinse loop runs 3×5 motor pairs, then `motor_fwd` for 200 ticks. The `j 0` then lands on halt: `halted`=1, `pc`=0, all outputs 0.
- `pause` raised mid-fill at timer=40 for 30 ticks → `fill_valve`=0 and timer frozen during the pause. After release, exactly 40 more ticks of fill.
- `dec` with R0=0, then `jz` R0 → R0=0xFFFF; branch not taken, `pc`+1. Opcode 0x7F, or `set` with reg=4 → `fault`=1, outputs 0; `stop` → IDLE, `pc`=0.
- `stop` during reverse at timer=5 → `motor_rev`=0 next cycle, `pc`=0, `busy`=0. `start` the same cycle as `stop` is ignored.
- With `WASH_SEQ_WATCHDOG_EN`, program `j` to self → `fault`=1 after 65 instructions. Without the macro, no fault after 1000 cycles.
